fifo_rd_streamer: RTL



---
 rtl/fifo_rd_streamer.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/fifo_rd_streamer.sv
// fifo_rd_streamer: read-side consumer for the dual-clock SRAM FIFO (rclk domain).
//
// A transfer starts on a `start` pulse in IDLE and latches `cfg_len`. The block then pops
// exactly that many words from the FIFO. It tracks the fixed RD_LAT read latency with a
// shift register of per-pop valid bits, captures each returning word into a small circular
// output buffer, and presents the buffer head on a valid/ready stream. Pops are
// credit-limited: a pop is issued only while buffered plus in-flight words leave room, so
// downstream back-pressure can never drop a popped word. When the last word has been
// consumed, `done` pulses for one cycle.
//
// Ports:
//   rclk         read-domain clock
//   rst_n        asynchronous active-low reset
//   start        single-cycle pulse, accepted only in IDLE
//   cfg_len      words to transfer, sampled on an accepted start
//   fifo_rempty  FIFO empty flag (registered in FIFO)
//   fifo_rdata   FIFO read data, valid RD_LAT cycles after a pop
//   fifo_rinc    pop request to FIFO
//   out_valid    out_data holds a word
//   out_data     head of output buffer
//   out_ready    downstream accepts when out_valid & out_ready
//   busy         high while running or flushing
//   done         one-cycle completion pulse
//   pop_cnt      words popped in the current transfer

module fifo_rd_streamer #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned RD_LAT     = 2,
    parameter int unsigned OBUF_DEPTH = 4,   // power of 2, >= RD_LAT + 1
    parameter int unsigned LEN_W      = 16
) (
    input  logic             rclk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             fifo_rempty,
    input  logic [WIDTH-1:0] fifo_rdata,
    output logic             fifo_rinc,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] pop_cnt
);

    localparam int unsigned PtrW = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
    // Wide enough for occupancy plus in-flight count without wrapping.
    localparam int unsigned CntW = PtrW + 2;
    localparam logic [CntW-1:0] DepthC = CntW'(OBUF_DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFlush,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] pop_cnt_q, pop_cnt_d;

    // One valid bit per outstanding pop; bit RD_LAT-1 marks the cycle in which
    // fifo_rdata carries that pop's word.
    logic [RD_LAT-1:0] inflight_q, inflight_d;
    logic [CntW-1:0]   inflight_cnt;

    logic [WIDTH-1:0] mem_q [OBUF_DEPTH];
    logic [PtrW-1:0]  wptr_q, rptr_q;
    logic [CntW-1:0]  occ_q, occ_d;

    logic [CntW-1:0] credit_sum;
    logic            capture;
    logic            drain;

    // ------------------------------------------------------------------
    // Credit and pop decision
    // ------------------------------------------------------------------
    always_comb begin
        inflight_cnt = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight_cnt = inflight_cnt + CntW'(inflight_q[i]);
        end
    end

    assign credit_sum = occ_q + inflight_cnt;

    assign fifo_rinc = (state_q == StRun) & ~fifo_rempty & (pop_cnt_q < len_q)
                     & (credit_sum < DepthC);

    assign capture = inflight_q[RD_LAT-1];
    assign drain   = out_valid & out_ready;

    // ------------------------------------------------------------------
    // Latency tracking shift register
    // ------------------------------------------------------------------
    always_comb begin
        inflight_d    = '0;
        inflight_d[0] = fifo_rinc;
        for (int i = 1; i < RD_LAT; i++) begin
            inflight_d[i] = inflight_q[i-1];
        end
    end

    // ------------------------------------------------------------------
    // Control FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        pop_cnt_d = pop_cnt_q;

        if (fifo_rinc) begin
            pop_cnt_d = pop_cnt_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    len_d     = cfg_len;
                    pop_cnt_d = '0;
                    state_d   = (cfg_len == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                // Counting this cycle's pop; the last pop moves straight to flush.
                if (pop_cnt_d >= len_q) begin
                    state_d = StFlush;
                end
            end
            StFlush: begin
                if ((inflight_q == '0) && (occ_q == '0)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output buffer occupancy
    // ------------------------------------------------------------------
    always_comb begin
        occ_d = occ_q;
        unique case ({capture, drain})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            len_q      <= '0;
            pop_cnt_q  <= '0;
            inflight_q <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            occ_q      <= '0;
            for (int i = 0; i < OBUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            pop_cnt_q  <= pop_cnt_d;
            inflight_q <= inflight_d;
            occ_q      <= occ_d;
            if (capture) begin
                mem_q[wptr_q] <= fifo_rdata;
                wptr_q        <= wptr_q + 1'b1;
            end
            if (drain) begin
                rptr_q <= rptr_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign out_valid = (occ_q != '0);
    assign out_data  = mem_q[rptr_q];
    assign busy      = (state_q == StRun) | (state_q == StFlush);
    assign done      = (state_q == StDone);
    assign pop_cnt   = pop_cnt_q;

endmodule
